// File: rtl/sgd_sched_pkg.sv
// Shared types and defaults for the serial loss-datapath sequencer.
// Holds the controller state encoding and the lead-counter width helper.
package sgd_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam int DEF_CREDIT_MAX = 48;
  localparam int DEF_SKEW_MAX   = 16;

  // Lead counters must be able to hold SKEW_MAX itself.
  function automatic int lead_width(input int skew_max);
    return $clog2(skew_max) + 1;
  endfunction

endpackage

// File: rtl/sgd_skew_tracker.sv
// Per-engine dot-product lead tracker: flags overflow when any engine runs
// SKEW_MAX valids ahead of the slowest one.
module sgd_skew_tracker
  import sgd_sched_pkg::*;
#(
  parameter int ENGINE_NUM = 8,
  parameter int SKEW_MAX   = DEF_SKEW_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ENGINE_NUM-1:0] dot_valid,
  input  logic                  enable,
  input  logic                  clear,
  output logic                  overflow
);

  localparam int LW = lead_width(SKEW_MAX);
  localparam logic [LW-1:0] SKEW_MAX_W = LW'(SKEW_MAX);

  logic [LW-1:0]         lead_reg [ENGINE_NUM];
  logic [LW-1:0]         lead_inc [ENGINE_NUM];
  logic [ENGINE_NUM-1:0] nonzero;
  logic [ENGINE_NUM-1:0] at_max;
  logic                  all_nonzero;

  genvar gi;
  generate
    for (gi = 0; gi < ENGINE_NUM; gi++) begin : g_lead
      // Saturate so a runaway engine cannot wrap back below the limit.
      assign lead_inc[gi] = (dot_valid[gi] && (lead_reg[gi] != SKEW_MAX_W))
                            ? lead_reg[gi] + 1'b1 : lead_reg[gi];
      assign nonzero[gi]  = (lead_inc[gi] != '0);
      assign at_max[gi]   = (lead_reg[gi] == SKEW_MAX_W);
    end
  endgenerate

  assign all_nonzero = &nonzero;
  assign overflow    = enable & (|at_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENGINE_NUM; i++) lead_reg[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < ENGINE_NUM; i++) lead_reg[i] <= '0;
    end else if (enable) begin
      for (int i = 0; i < ENGINE_NUM; i++) lead_reg[i] <= lead_inc[i] - LW'(all_nonzero);
    end
  end

endmodule

// File: rtl/sgd_loss_sched.sv
// Batch sequencer for the serial loss datapath: credit-limited token issue,
// retire accounting, engine skew supervision and host done/error reporting.
module sgd_loss_sched
  import sgd_sched_pkg::*;
#(
  parameter int ENGINE_NUM      = 8,
  parameter int FIFO_DEPTH_BITS = 6,
  parameter int CREDIT_MAX      = DEF_CREDIT_MAX,
  parameter int SKEW_MAX        = DEF_SKEW_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              num_samples,
  input  logic [31:0]              step_size_in,
  output logic [31:0]              step_size,
  input  logic                     sample_issue_ready,
  output logic                     sample_issue,
  input  logic [ENGINE_NUM-1:0]    dot_valid,
  input  logic                     result_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     skew_err,
  output logic                     proto_err,
  output logic [FIFO_DEPTH_BITS:0] in_flight
);

  localparam int IFW = FIFO_DEPTH_BITS + 1;
  localparam logic [IFW-1:0] CREDIT_W = IFW'(CREDIT_MAX);

  state_t          state_reg, state_next;
  logic [31:0]     num_reg, issued_reg, retired_reg, step_reg;
  logic [IFW-1:0]  in_flight_reg;
  logic            skew_err_reg, proto_err_reg;

  logic            start_ok, issue, retire, proto_hit, tracking, skew_ovf;
  logic [31:0]     issued_plus;

  assign start_ok    = start && (state_reg == ST_IDLE);
  assign tracking    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  // Credit check uses the pre-update in_flight, so a same-cycle retire frees nothing yet.
  assign issue       = (state_reg == ST_RUN) && (issued_reg < num_reg) &&
                       (in_flight_reg < CREDIT_W) && sample_issue_ready;
  assign retire      = result_valid && (in_flight_reg != '0);
  assign proto_hit   = result_valid && (in_flight_reg == '0);
  assign issued_plus = issued_reg + 32'(issue);

  sgd_skew_tracker #(
    .ENGINE_NUM (ENGINE_NUM),
    .SKEW_MAX   (SKEW_MAX)
  ) u_skew (
    .clk       (clk),
    .rst       (rst),
    .dot_valid (dot_valid),
    .enable    (tracking),
    .clear     (abort | start_ok),
    .overflow  (skew_ovf)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = (num_samples == 32'd0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (issued_plus == num_reg) state_next = ST_DRAIN;
      ST_DRAIN: if (retired_reg == num_reg) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_ERR;
      default:  state_next = ST_IDLE;
    endcase
    if (skew_ovf) state_next = ST_ERR;
    if (abort)    state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      num_reg       <= '0;
      issued_reg    <= '0;
      retired_reg   <= '0;
      step_reg      <= '0;
      in_flight_reg <= '0;
      skew_err_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (abort) begin
        issued_reg    <= '0;
        retired_reg   <= '0;
        in_flight_reg <= '0;
      end else if (start_ok) begin
        num_reg       <= num_samples;
        step_reg      <= step_size_in;
        issued_reg    <= '0;
        retired_reg   <= '0;
        in_flight_reg <= '0;
        skew_err_reg  <= 1'b0;
        proto_err_reg <= 1'b0;
      end else begin
        issued_reg  <= issued_plus;
        retired_reg <= retired_reg + 32'(retire);
        if (issue && !retire)      in_flight_reg <= in_flight_reg + 1'b1;
        else if (retire && !issue) in_flight_reg <= in_flight_reg - 1'b1;
      end
      if (skew_ovf && !abort) skew_err_reg  <= 1'b1;
      if (proto_hit)          proto_err_reg <= 1'b1;
    end
  end

  assign sample_issue = issue;
  assign step_size    = step_reg;
  assign busy         = tracking;
  assign done         = (state_reg == ST_DONE);
  assign skew_err     = skew_err_reg;
  assign proto_err    = proto_err_reg;
  assign in_flight    = in_flight_reg;

endmodule

// File: tb/tb_sgd_loss_sched.sv
// Scoreboard bench for sgd_loss_sched: a behavioural batch model predicts
// every cycle's outputs into a queue that a separate monitor drains and checks.
module tb_sgd_loss_sched;
  localparam int EN = 8;
  localparam int CM = 48;
  localparam int SM = 16;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0]   num_samples = '0, step_size_in = '0;
  wire  [31:0]   step_size;
  logic          ready = 1'b0;
  wire           sample_issue;
  logic [EN-1:0] dot_valid = '0;
  logic          rv_resp = 1'b0, rv_man = 1'b0;
  wire           result_valid = rv_resp | rv_man;
  wire           busy, done, skew_err, proto_err;
  wire  [6:0]    in_flight;

  sgd_loss_sched #(.ENGINE_NUM(EN), .FIFO_DEPTH_BITS(6), .CREDIT_MAX(CM), .SKEW_MAX(SM)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_samples(num_samples), .step_size_in(step_size_in), .step_size(step_size),
    .sample_issue_ready(ready), .sample_issue(sample_issue), .dot_valid(dot_valid),
    .result_valid(result_valid), .busy(busy), .done(done), .skew_err(skew_err),
    .proto_err(proto_err), .in_flight(in_flight)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE, M_ERR} mph_t;
  mph_t        ph = M_IDLE;
  int unsigned m_num = 0, m_iss = 0, m_ret = 0, m_if = 0;
  logic [31:0] m_step = '0;
  bit          m_skew = 0, m_proto = 0;
  int          m_lead [EN];

  function bit m_issue_now();
    return (ph == M_RUN) && (m_iss < m_num) && (m_if < CM) && (ready === 1'b1);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit   iss, ret, ovf, tracking, all1, proto_now;
    mph_t nxt;
    if (rst) begin
      ph = M_IDLE; m_num = 0; m_iss = 0; m_ret = 0; m_if = 0; m_step = '0;
      m_skew = 0; m_proto = 0;
      for (int e = 0; e < EN; e++) m_lead[e] = 0;
    end else begin
      iss       = m_issue_now();
      ret       = (result_valid === 1'b1) && (m_if > 0);
      proto_now = (result_valid === 1'b1) && (m_if == 0);
      tracking  = (ph == M_RUN) || (ph == M_DRAIN);
      ovf = 0;
      for (int e = 0; e < EN; e++) if (tracking && m_lead[e] >= SM) ovf = 1;
      if (abort) begin
        ph = M_IDLE; m_iss = 0; m_ret = 0; m_if = 0;
        for (int e = 0; e < EN; e++) m_lead[e] = 0;
      end else begin
        nxt = ph;
        case (ph)
          M_IDLE: if (start) begin
            m_num = num_samples; m_step = step_size_in;
            m_iss = 0; m_ret = 0; m_if = 0; m_skew = 0; m_proto = 0;
            for (int e = 0; e < EN; e++) m_lead[e] = 0;
            nxt = (num_samples == 0) ? M_DONE : M_RUN;
          end
          M_RUN:   if (m_iss + iss == m_num) nxt = M_DRAIN;
          M_DRAIN: if (m_ret == m_num) nxt = M_DONE;
          M_DONE:  nxt = M_IDLE;
          default: nxt = ph;
        endcase
        if (!(ph == M_IDLE && start)) begin
          m_iss += iss; m_ret += ret; m_if = m_if + iss - ret;
        end
        if (tracking) begin
          for (int e = 0; e < EN; e++) if (dot_valid[e] && m_lead[e] < SM) m_lead[e]++;
          all1 = 1;
          for (int e = 0; e < EN; e++) if (m_lead[e] < 1) all1 = 0;
          if (all1) for (int e = 0; e < EN; e++) m_lead[e]--;
        end
        if (ovf) begin nxt = M_ERR; m_skew = 1; end
        ph = nxt;
      end
      if (proto_now) m_proto = 1;
    end
  end

  // ---------------- predictor -> queue -> monitor ----------------
  typedef struct {
    bit          issue, dn, bsy, skew, proto;
    int unsigned inf;
    logic [31:0] step;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    exp_t p;
    p.issue = m_issue_now();
    p.dn    = (ph == M_DONE);
    p.bsy   = (ph == M_RUN) || (ph == M_DRAIN);
    p.skew  = m_skew;
    p.proto = m_proto;
    p.inf   = m_if;
    p.step  = m_step;
    exp_q.push_back(p);
  end

  int obs_issue = 0, obs_done = 0, max_if = 0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() == 0) begin
      chk("sb_queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sample_issue", 32'(sample_issue), 32'(e.issue));
      chk("done",         32'(done),         32'(e.dn));
      chk("busy",         32'(busy),         32'(e.bsy));
      chk("skew_err",     32'(skew_err),     32'(e.skew));
      chk("proto_err",    32'(proto_err),    32'(e.proto));
      chk("in_flight",    32'(in_flight),    e.inf);
      chk("step_size",    step_size,         e.step);
      if (sample_issue === 1'b1) obs_issue++;
      if (done === 1'b1) obs_done++;
      if (int'(in_flight) > max_if) max_if = int'(in_flight);
    end
  end

  // ---------------- retire responder ----------------
  int unsigned cyc = 0, last_rt = 0;
  int unsigned rt_q[$];
  bit          resp_on = 0;
  int unsigned lat_min = 12, lat_max = 12;

  always @(negedge clk) begin
    int unsigned t;
    if (resp_on && sample_issue === 1'b1) begin
      t = cyc + $urandom_range(lat_max, lat_min);
      if (t <= last_rt) t = last_rt + 1;
      rt_q.push_back(t);
      last_rt = t;
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rt_q.size() > 0 && rt_q[0] <= cyc) begin
      void'(rt_q.pop_front());
      rv_resp = 1'b1;
    end else begin
      rv_resp = 1'b0;
    end
  end

  bit rand_on = 0;
  always @(posedge clk) begin
    #1;
    if (rand_on) begin
      ready     = ($urandom_range(3, 0) != 0);
      dot_valid = ($urandom_range(1, 0) != 0) ? '1 : '0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input logic [31:0] n, input logic [31:0] s);
    start = 1'b1; num_samples = n; step_size_in = s;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int c0, k;
    c0 = obs_done; k = 0;
    while (obs_done == c0 && k < bound) begin tick(); k++; end
    chk(name, 32'(obs_done != c0), 32'd1);
  endtask

  initial begin
    int iss0;
    logic [31:0] n;
    tick(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_flight", 32'(in_flight), 32'd0);
    chk("rst_step", step_size, 32'd0);
    rst = 1'b0;
    tick(2);

    // batch of 10, fixed 12-cycle retire latency
    ready = 1'b1; resp_on = 1; obs_issue = 0; obs_done = 0; max_if = 0;
    pulse_start(32'd10, 32'd3);
    wait_done(200, "t1_done_timeout");
    tick(3);
    chk("t1_issues", 32'(obs_issue), 32'd10);
    chk("t1_peak_in_flight", 32'(max_if), 32'd10);
    chk("t1_done_count", 32'(obs_done), 32'd1);
    $display("batch n=10: issues %0d peak %0d done %0d", obs_issue, max_if, obs_done);

    // credit limit with no retires
    resp_on = 0; tick(5); obs_issue = 0;
    pulse_start(32'd100, 32'd7);
    tick(70);
    chk("t2_issues", 32'(obs_issue), 32'd48);
    chk("t2_in_flight", 32'(in_flight), 32'd48);
    chk("t2_blocked", 32'(sample_issue), 32'd0);
    rv_man = 1'b1; tick(); rv_man = 1'b0; tick(3);
    chk("t2_one_more_issue", 32'(obs_issue), 32'd49);
    chk("t2_refill", 32'(in_flight), 32'd48);
    $display("credit test: issues %0d in_flight %0d", obs_issue, in_flight);

    // retire at full credit, then issue+retire in one cycle
    rv_man = 1'b1; #1;
    chk("t3_full_blocks_issue", 32'(sample_issue), 32'd0);
    tick();
    chk("t3_after_retire", 32'(in_flight), 32'd47);
    chk("t3_both_issue", 32'(sample_issue), 32'd1);
    tick(); rv_man = 1'b0;
    chk("t3_both_unchanged", 32'(in_flight), 32'd47);
    tick();
    chk("t3_refill", 32'(in_flight), 32'd48);
    pulse_abort(); tick();
    chk("t3_abort_in_flight", 32'(in_flight), 32'd0);
    chk("t3_abort_busy", 32'(busy), 32'd0);
    $display("same-cycle issue/retire and abort: in_flight %0d", in_flight);

    // engine 3 runs ahead
    ready = 1'b0;
    pulse_start(32'd1000, 32'd9);
    dot_valid = 8'h08; tick(16); dot_valid = '0; tick(3);
    chk("t4_skew_err", 32'(skew_err), 32'd1);
    chk("t4_err_busy", 32'(busy), 32'd0);
    pulse_abort(); tick();
    chk("t4_skew_sticky", 32'(skew_err), 32'd1);
    iss0 = obs_issue;
    pulse_start(32'd0, 32'd5);
    chk("t4_start_clears_skew", 32'(skew_err), 32'd0);
    chk("t6_step_latched", step_size, 32'd5);
    chk("t6_done_pulse", 32'(done), 32'd1);
    tick();
    chk("t6_done_once", 32'(done), 32'd0);
    chk("t6_no_issue", 32'(obs_issue - iss0), 32'd0);
    $display("skew error, abort, zero-length batch: step %0d", step_size);

    // retire with nothing in flight
    tick(2); rv_man = 1'b1; tick(); rv_man = 1'b0;
    chk("t5_proto_err", 32'(proto_err), 32'd1);
    chk("t5_in_flight", 32'(in_flight), 32'd0);
    $display("idle retire: proto_err %0d", proto_err);

    // randomized batches
    resp_on = 1; lat_min = 1; lat_max = 20; rand_on = 1;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(70, 1);
      obs_issue = 0;
      pulse_start(n, $urandom);
      wait_done(3000, "rand_done_timeout");
      chk("rand_issues", 32'(obs_issue), n);
      $display("random batch %0d: n=%0d issues %0d", b, n, obs_issue);
    end
    rand_on = 0; resp_on = 0; dot_valid = '0; tick(25);

    // asynchronous reset in the middle of a batch
    ready = 1'b1;
    pulse_start(32'd30, 32'd11);
    tick(5);
    rst = 1'b1; #1;
    chk("t8_rst_step", step_size, 32'd0);
    chk("t8_rst_in_flight", 32'(in_flight), 32'd0);
    chk("t8_rst_busy", 32'(busy), 32'd0);
    chk("t8_rst_issue", 32'(sample_issue), 32'd0);
    tick(2); rst = 1'b0; tick(3);
    $display("mid-run reset: busy %0d in_flight %0d", busy, in_flight);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
